// File: rtl/step_sequencer_core.sv
// Multi-track step sequencer core.
//
// A divider derived from CLOCK_50 sets the step tempo. A per-track, per-step store holds a note
// code and a valid bit for each step. The loop length is programmable, each step's gate is high
// for the first half of the step, and any one track can be replaced by a live key input.
// Outputs are registered note/gate pairs per track plus step position and tick strobes.
//
// Ports:
//   CLOCK_50     system clock
//   RESET_N      asynchronous active-low reset; release is synchronised internally
//   RUN          1 = sequencing, 0 = stopped (held at step 0)
//   BEAT_DIV     CLOCK_50 cycles per step (0 behaves as 1)
//   LENGTH       active loop length in steps (0 or >STEPS behaves as STEPS)
//   WR_EN        single-cycle store write strobe
//   WR_TRACK     track targeted by the write (out-of-range values are ignored)
//   WR_MASK      bit i selects step i
//   WR_NOTE      note written to the selected steps
//   WR_CLEAR     with WR_EN, clear valid on the selected steps instead of writing
//   LIVE_EN      enable live override
//   LIVE_TRACK   track replaced by the live input (out-of-range values disable override)
//   LIVE_NOTE    live note code
//   LIVE_GATE    live key held
//   STEP_NUM     current step index
//   STEP_ONEHOT  one-hot decode of STEP_NUM
//   STEP_TICK    pulse on the first cycle of each new step
//   CYCLE_TICK   pulse alongside STEP_TICK when the step wraps to 0
//   NOTE_OUT     per-track note, track t at [t*NOTE_W +: NOTE_W]
//   GATE_OUT     per-track gate
module step_sequencer_core #(
    parameter int unsigned STEPS  = 8,
    parameter int unsigned TRACKS = 2,
    parameter int unsigned NOTE_W = 4,
    parameter int unsigned DIV_W  = 24,
    parameter int unsigned LEN_W  = $clog2(STEPS) + 1,
    parameter int unsigned STEP_W = $clog2(STEPS),
    parameter int unsigned TRK_W  = (TRACKS > 1) ? $clog2(TRACKS) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    input  logic                     RUN,
    input  logic [DIV_W-1:0]         BEAT_DIV,
    input  logic [LEN_W-1:0]         LENGTH,
    input  logic                     WR_EN,
    input  logic [TRK_W-1:0]         WR_TRACK,
    input  logic [STEPS-1:0]         WR_MASK,
    input  logic [NOTE_W-1:0]        WR_NOTE,
    input  logic                     WR_CLEAR,
    input  logic                     LIVE_EN,
    input  logic [TRK_W-1:0]         LIVE_TRACK,
    input  logic [NOTE_W-1:0]        LIVE_NOTE,
    input  logic                     LIVE_GATE,
    output logic [STEP_W-1:0]        STEP_NUM,
    output logic [STEPS-1:0]         STEP_ONEHOT,
    output logic                     STEP_TICK,
    output logic                     CYCLE_TICK,
    output logic [TRACKS*NOTE_W-1:0] NOTE_OUT,
    output logic [TRACKS-1:0]        GATE_OUT
);

    // Reset: asserts asynchronously, releases after two clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // State
    logic [DIV_W-1:0]                         cnt_q, cnt_d;
    logic [STEP_W-1:0]                        step_q, step_d;
    logic                                     step_tick_q, step_tick_d;
    logic                                     cycle_tick_q, cycle_tick_d;
    logic [TRACKS-1:0][STEPS-1:0]             valid_q, valid_d;
    logic [TRACKS-1:0][STEPS-1:0][NOTE_W-1:0] note_q, note_d;
    logic [TRACKS*NOTE_W-1:0]                 note_out_q, note_out_d;
    logic [TRACKS-1:0]                        gate_out_q, gate_out_d;

    // Effective tempo/length values
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] half_eff;
    logic [LEN_W-1:0] len_eff;
    logic             advance;
    logic             wrap;

    always_comb begin
        div_eff  = (BEAT_DIV == '0) ? DIV_W'(1) : BEAT_DIV;
        half_eff = div_eff >> 1;
        if (half_eff == '0) begin
            half_eff = DIV_W'(1);
        end
        len_eff  = ((LENGTH == '0) || (LENGTH > LEN_W'(STEPS))) ? LEN_W'(STEPS) : LENGTH;
        // >= rather than == so a shrunk BEAT_DIV or LENGTH takes effect on the next cycle.
        advance  = (cnt_q >= (div_eff - DIV_W'(1)));
        wrap     = (LEN_W'(step_q) >= (len_eff - LEN_W'(1)));
    end

    // Divider and step position. Stopped state parks at step 0 / cnt 0, so a restart begins
    // step 0 without a tick.
    always_comb begin
        cnt_d        = '0;
        step_d       = '0;
        step_tick_d  = 1'b0;
        cycle_tick_d = 1'b0;
        if (RUN) begin
            if (advance) begin
                step_d       = wrap ? '0 : step_q + STEP_W'(1);
                step_tick_d  = 1'b1;
                cycle_tick_d = wrap;
            end else begin
                cnt_d  = cnt_q + DIV_W'(1);
                step_d = step_q;
            end
        end
    end

    // Note/valid store. Tracks beyond TRACKS never match, so such writes fall through.
    always_comb begin
        valid_d = valid_q;
        note_d  = note_q;
        for (int t = 0; t < TRACKS; t++) begin
            if (WR_EN && (WR_TRACK == TRK_W'(t))) begin
                for (int i = 0; i < STEPS; i++) begin
                    if (WR_MASK[i]) begin
                        if (WR_CLEAR) begin
                            valid_d[t][i] = 1'b0;
                        end else begin
                            valid_d[t][i] = 1'b1;
                            note_d[t][i]  = WR_NOTE;
                        end
                    end
                end
            end
        end
    end

    // Per-track outputs, one cycle behind the state they are derived from.
    always_comb begin
        note_out_d = '0;
        gate_out_d = '0;
        for (int t = 0; t < TRACKS; t++) begin
            if (LIVE_EN && (LIVE_TRACK == TRK_W'(t))) begin
                note_out_d[t*NOTE_W +: NOTE_W] = LIVE_NOTE;
                gate_out_d[t]                  = LIVE_GATE;
            end else begin
                if (valid_q[t][step_q]) begin
                    note_out_d[t*NOTE_W +: NOTE_W] = note_q[t][step_q];
                end
                // Gate drops for the second half of the step so repeated notes retrigger.
                gate_out_d[t] = RUN & valid_q[t][step_q] & (cnt_q < half_eff);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            step_q       <= '0;
            step_tick_q  <= 1'b0;
            cycle_tick_q <= 1'b0;
            valid_q      <= '0;
            note_q       <= '0;
            note_out_q   <= '0;
            gate_out_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            step_tick_q  <= step_tick_d;
            cycle_tick_q <= cycle_tick_d;
            valid_q      <= valid_d;
            note_q       <= note_d;
            note_out_q   <= note_out_d;
            gate_out_q   <= gate_out_d;
        end
    end

    assign STEP_NUM    = step_q;
    assign STEP_ONEHOT = STEPS'(1) << step_q;
    assign STEP_TICK   = step_tick_q;
    assign CYCLE_TICK  = cycle_tick_q;
    assign NOTE_OUT    = note_out_q;
    assign GATE_OUT    = gate_out_q;

endmodule
